// File: rtl/ym3438_mixer_pkg.sv
// Shared definitions for the YM3438-style stereo channel mixer.
//   - FSM state encoding (IDLE / ACCUM / EMIT)
//   - acc_width(): accumulator width for a given sample width and slot count
//   - saturate() / sat_clips(): signed clamp helpers on a 64-bit carrier
package ym3438_mixer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    // Two guard bits cover the ladder offset on top of the per-slot growth.
    function automatic int acc_width(input int in_w, input int num_ch);
        return in_w + $clog2(num_ch) + 2;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic logic sat_clips(input logic signed [63:0] v, input int out_w);
        return saturate(v, out_w) != v;
    endfunction

endpackage

// File: rtl/ym3438_mixer_sat.sv
// Combinational signed clamp from an ACC_W-bit accumulator to OUT_W bits.
// Ports:
//   din   in   ACC_W  signed accumulator value
//   dout  out  OUT_W  clamped value
//   clip  out  1      din was outside the OUT_W signed range
module ym3438_mixer_sat
    import ym3438_mixer_pkg::*;
#(
    parameter int ACC_W = 14,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    assign dout = OUT_W'(saturate(64'(din), OUT_W));
    assign clip = sat_clips(64'(din), OUT_W);

endmodule

// File: rtl/ym3438_mixer.sv
// Stereo channel mixer: sums NUM_CH panned channel samples per frame into
// left/right accumulators, optionally adding the DAC ladder-effect offset,
// and presents saturated results once per frame.
// Ports:
//   MCLK         in   1      clock
//   reset        in   1      synchronous active-high reset
//   en           in   1      clock enable; state advances only when high
//   frame_sync   in   1      marks slot 0 of a frame (needs ch_valid)
//   ch_valid     in   1      ch_data/ch_pan carry one channel slot
//   ch_data      in   IN_W   signed channel sample
//   ch_pan       in   2      bit1 left enable, bit0 right enable
//   ladder_mode  in   1      add ladder offset to every slot
//   out_l/out_r  out  OUT_W  saturated frame sums, held between strobes
//   out_valid    out  1      one-en-cycle strobe on new result
//   overflow     out  1      sticky: a result was clamped
//   frame_err    out  1      sticky: frame restarted before NUM_CH slots
//
// state | meaning
// IDLE  | waiting for frame_sync & ch_valid
// ACCUM | summing slots 1..NUM_CH-1
// EMIT  | publish result; a new frame may start in the same cycle
module ym3438_mixer
    import ym3438_mixer_pkg::*;
#(
    parameter int NUM_CH     = 6,
    parameter int IN_W       = 9,
    parameter int OUT_W      = 16,
    parameter int LADDER_OFF = 4
) (
    input  logic                   MCLK,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   frame_sync,
    input  logic                   ch_valid,
    input  logic signed [IN_W-1:0] ch_data,
    input  logic [1:0]             ch_pan,
    input  logic                   ladder_mode,
    output logic signed [OUT_W-1:0] out_l,
    output logic signed [OUT_W-1:0] out_r,
    output logic                   out_valid,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam int ACC_W  = acc_width(IN_W, NUM_CH);
    localparam int SLOT_W = $clog2(NUM_CH + 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH);
    localparam logic signed [ACC_W-1:0] OFF = ACC_W'(LADDER_OFF);
    // A one-slot frame is complete as soon as slot 0 is loaded.
    localparam logic [1:0] FIRST_ST = (NUM_CH == 1) ? ST_EMIT : ST_ACCUM;

    logic [1:0]              state;
    logic [SLOT_W-1:0]       slot_cnt;
    logic signed [ACC_W-1:0] acc_l, acc_r;
    logic signed [ACC_W-1:0] add_l, add_r;
    logic signed [OUT_W-1:0] sat_l, sat_r;
    logic                    clip_l, clip_r;
    logic                    start;
    logic [SLOT_W-1:0]       slot_next;

    function automatic logic signed [ACC_W-1:0] contrib(input logic side_en);
        logic signed [ACC_W-1:0] d;
        logic                    neg;
        d   = ACC_W'(ch_data);
        neg = ch_data[IN_W-1];
        if (ladder_mode)
            // Disabled side still sees the ladder offset, signed like the sample.
            return side_en ? (neg ? d - OFF : d + OFF) : (neg ? -OFF : OFF);
        else
            return side_en ? d : '0;
    endfunction

    always_comb begin
        add_l     = contrib(ch_pan[1]);
        add_r     = contrib(ch_pan[0]);
        start     = frame_sync & ch_valid;
        slot_next = slot_cnt + SLOT_ONE;
    end

    ym3438_mixer_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
        .din  (acc_l),
        .dout (sat_l),
        .clip (clip_l)
    );

    ym3438_mixer_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
        .din  (acc_r),
        .dout (sat_r),
        .clip (clip_r)
    );

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state     <= ST_IDLE;
            slot_cnt  <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (en) begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc_l    <= add_l;
                        acc_r    <= add_r;
                        slot_cnt <= SLOT_ONE;
                        state    <= FIRST_ST;
                    end
                end
                ST_ACCUM: begin
                    if (start) begin
                        frame_err <= 1'b1;
                        acc_l     <= add_l;
                        acc_r     <= add_r;
                        slot_cnt  <= SLOT_ONE;
                        state     <= FIRST_ST;
                    end else if (ch_valid) begin
                        acc_l    <= acc_l + add_l;
                        acc_r    <= acc_r + add_r;
                        slot_cnt <= slot_next;
                        if (slot_next == SLOT_LAST)
                            state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    out_l     <= sat_l;
                    out_r     <= sat_r;
                    out_valid <= 1'b1;
                    if (clip_l | clip_r)
                        overflow <= 1'b1;
                    if (start) begin
                        acc_l    <= add_l;
                        acc_r    <= add_r;
                        slot_cnt <= SLOT_ONE;
                        state    <= FIRST_ST;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ym3438_mixer.sv
// Self-checking bench for ym3438_mixer (NUM_CH=6, IN_W=9, OUT_W=10, LADDER_OFF=4).
module tb_ym3438_mixer;

    logic              MCLK = 1'b0;
    logic              reset;
    logic              en;
    logic              frame_sync;
    logic              ch_valid;
    logic signed [8:0] ch_data;
    logic [1:0]        ch_pan;
    logic              ladder_mode;
    logic signed [9:0] out_l, out_r;
    logic              out_valid, overflow, frame_err;

    int n_cmp = 0;
    int n_err = 0;

    ym3438_mixer #(.NUM_CH(6), .IN_W(9), .OUT_W(10), .LADDER_OFF(4)) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .en          (en),
        .frame_sync  (frame_sync),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_pan      (ch_pan),
        .ladder_mode (ladder_mode),
        .out_l       (out_l),
        .out_r       (out_r),
        .out_valid   (out_valid),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        int         data;
        logic [1:0] pan;
        logic       lad;
        int         exp_l;
        int         exp_r;
        int         exp_ovf;
    } frame_vec_t;

    frame_vec_t vecs[9];

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic slot(input int data, input logic [1:0] pan, input logic sync,
                        input logic lad);
        ch_valid    = 1'b1;
        frame_sync  = sync;
        ch_data     = 9'(data);
        ch_pan      = pan;
        ladder_mode = lad;
        tick();
    endtask

    task automatic idle_in();
        ch_valid   = 1'b0;
        frame_sync = 1'b0;
    endtask

    // Emit cycle after the sixth slot: strobe and result, then strobe drops.
    task automatic expect_result(input string tag, input int el, input int er);
        idle_in();
        check({tag, " pre_valid"}, out_valid, 0);
        tick();
        check({tag, " valid"}, out_valid, 1);
        check({tag, " out_l"}, out_l, el);
        check({tag, " out_r"}, out_r, er);
        tick();
        check({tag, " valid_drop"}, out_valid, 0);
        check({tag, " hold_l"}, out_l, el);
    endtask

    task automatic run_frame(input string tag, input int data, input logic [1:0] pan,
                             input logic lad, input int el, input int er);
        for (int i = 0; i < 6; i++)
            slot(data, pan, (i == 0), lad);
        expect_result(tag, el, er);
    endtask

    initial begin
        int vcount;

        vecs[0] = '{10,   2'b11, 1'b0,   60,   60, 0};
        vecs[1] = '{-3,   2'b10, 1'b1,  -42,  -24, 0};
        vecs[2] = '{-3,   2'b01, 1'b1,  -24,  -42, 0};
        vecs[3] = '{7,    2'b01, 1'b0,    0,   42, 0};
        vecs[4] = '{0,    2'b00, 1'b1,   24,   24, 0};
        vecs[5] = '{5,    2'b00, 1'b0,    0,    0, 0};
        vecs[6] = '{255,  2'b11, 1'b0,  511,  511, 1};
        vecs[7] = '{-1,   2'b11, 1'b0,   -6,   -6, 1};
        vecs[8] = '{-100, 2'b11, 1'b0, -512, -512, 1};

        // Reset with en low must still clear everything.
        reset = 1'b1; en = 1'b0; frame_sync = 1'b0; ch_valid = 1'b0;
        ch_data = '0; ch_pan = 2'b00; ladder_mode = 1'b0;
        tick(); tick();
        check("rst out_l", out_l, 0);
        check("rst out_r", out_r, 0);
        check("rst out_valid", out_valid, 0);
        check("rst overflow", overflow, 0);
        check("rst frame_err", frame_err, 0);
        reset = 1'b0; en = 1'b1;
        tick();

        for (int v = 0; v < 9; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].pan, vecs[v].lad,
                      vecs[v].exp_l, vecs[v].exp_r);
            check($sformatf("vec%0d overflow", v), overflow, vecs[v].exp_ovf);
            check($sformatf("vec%0d frame_err", v), frame_err, 0);
        end

        // Reset after slot 4 discards the partial frame.
        for (int i = 0; i < 4; i++)
            slot(2, 2'b11, (i == 0), 1'b0);
        idle_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst out_l", out_l, 0);
        check("midrst out_r", out_r, 0);
        check("midrst overflow", overflow, 0);
        check("midrst frame_err", frame_err, 0);
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vcount += int'(out_valid);
        end
        check("midrst no_valid", vcount, 0);
        run_frame("fresh", 2, 2'b11, 1'b0, 12, 12);

        // ch_valid without sync in IDLE and sync without valid are ignored.
        slot(50, 2'b11, 1'b0, 1'b0);
        slot(50, 2'b11, 1'b0, 1'b0);
        idle_in(); frame_sync = 1'b1;
        tick();
        slot(1, 2'b11, 1'b1, 1'b0);
        slot(1, 2'b11, 1'b0, 1'b0);
        idle_in(); frame_sync = 1'b1;
        tick();
        for (int i = 0; i < 4; i++)
            slot(1, 2'b11, 1'b0, 1'b0);
        expect_result("ignore", 6, 6);
        check("ignore frame_err", frame_err, 0);

        // ladder_mode switched mid-frame: 3*1 + 3*(1+4).
        for (int i = 0; i < 6; i++)
            slot(1, 2'b11, (i == 0), (i >= 3));
        expect_result("ladmid", 18, 18);

        // Early restart at slot 3 drops the partial frame.
        for (int i = 0; i < 3; i++)
            slot(7, 2'b11, (i == 0), 1'b0);
        slot(1, 2'b11, 1'b1, 1'b0);
        check("restart frame_err", frame_err, 1);
        check("restart no_valid", out_valid, 0);
        for (int i = 0; i < 5; i++)
            slot(1, 2'b11, 1'b0, 1'b0);
        expect_result("restart", 6, 6);
        check("restart err_sticky", frame_err, 1);

        // New frame starting in the emit cycle loses no slot.
        for (int i = 0; i < 6; i++)
            slot(10, 2'b11, (i == 0), 1'b0);
        slot(3, 2'b11, 1'b1, 1'b0);
        check("b2b valid", out_valid, 1);
        check("b2b out_l", out_l, 60);
        for (int i = 0; i < 5; i++)
            slot(3, 2'b11, 1'b0, 1'b0);
        expect_result("b2b second", 18, 18);

        // en toggling every cycle.
        for (int i = 0; i < 6; i++) begin
            en = 1'b1;
            slot(5, 2'b11, (i == 0), 1'b0);
            en = 1'b0;
            tick();
        end
        idle_in();
        vcount = 0;
        for (int j = 0; j < 8; j++) begin
            en = (j % 2 == 0);
            if (en && out_valid)
                vcount++;
            if (!en && j == 1)
                check("entog frozen_valid", out_valid, 1);
            tick();
        end
        en = 1'b1;
        check("entog valid_cnt", vcount, 1);
        check("entog out_l", out_l, 30);
        check("entog out_r", out_r, 30);
        check("entog overflow", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
